// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for the partitioned FIFO with a 2-entry valid/ready output buffer
module fifo_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_DATA   = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
);
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(MAX_DATA);

    logic [ADDR_WIDTH:0]   count_q, count_d, unfetched_q, unfetched_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic                  inflight_q, inflight_d, overflow_q, overflow_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d, head, second;
    logic                  acc, pop, fetch;

    assign full        = count_q == FULL_CNT;
    assign empty       = count_q == '0;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign rd_valid    = buf_cnt_q != 2'd0 || inflight_q;
    assign rd_data     = head;
    assign mem_rd_en   = fetch;
    assign mem_rd_addr = rd_ptr_q;

    // Next-state logic; the arriving memory word is presented directly when the buffer is empty,
    // so the entry queue is buf0, buf1 (as filled) followed by the in-flight word.
    always_comb begin
        acc         = wr_en && !full;
        head        = (buf_cnt_q != 2'd0 || !inflight_q) ? buf0_q : mem_rd_data;
        second      = (buf_cnt_q == 2'd2) ? buf1_q : mem_rd_data;
        pop         = rd_valid && rd_ready;
        buf_cnt_d   = buf_cnt_q + 2'(inflight_q) - 2'(pop);
        fetch       = unfetched_q != '0 && buf_cnt_d < 2'd2;
        buf0_d      = (buf_cnt_d == 2'd0) ? (pop ? head : buf0_q) : (pop ? second : head);
        buf1_d      = pop ? mem_rd_data : second;
        inflight_d  = fetch;
        rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(fetch);
        count_d     = count_q + (ADDR_WIDTH+1)'(acc) - (ADDR_WIDTH+1)'(pop);
        unfetched_d = unfetched_q + (ADDR_WIDTH+1)'(acc) - (ADDR_WIDTH+1)'(fetch);
        overflow_d  = wr_en && full;
    end

    // State registers; reset discards buffered and in-flight data and rewinds the read pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            unfetched_q <= '0;
            rd_ptr_q    <= '0;
            inflight_q  <= 1'b0;
            overflow_q  <= 1'b0;
            buf_cnt_q   <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
        end else begin
            count_q     <= count_d;
            unfetched_q <= unfetched_d;
            rd_ptr_q    <= rd_ptr_d;
            inflight_q  <= inflight_d;
            overflow_q  <= overflow_d;
            buf_cnt_q   <= buf_cnt_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
        end
    end
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: scoreboard bench for fifo_reader with a behavioural writer and 256x8 memory
module tb_fifo_reader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_ready = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       mem_rd_en;
    logic [7:0] mem_rd_addr;
    logic [7:0] mem_rd_data = 8'h00;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [8:0] count;
    logic       empty, full, overflow;

    logic [7:0] mem [256];
    logic [7:0] wp;
    logic [7:0] q [$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         exp_count = 0;
    logic       exp_ovf = 1'b0;
    logic [7:0] exp_raddr = 8'h00;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic       want_valid = 1'b0;

    fifo_reader dut (
        .clk(clk), .rst(rst), .wr_en(wr_en),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .count(count), .empty(empty), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // writer partition model: commits on wr_en unless full
    always @(posedge clk or posedge rst) begin
        if (rst) wp <= 8'h00;
        else if (wr_en && !full) begin
            mem[wp] <= wr_data;
            wp <= wp + 8'd1;
        end
    end

    // synchronous storage read port
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // buffered plus in-flight entries never exceed two
    always @(negedge clk) if (!rst) check("occ", 32'({1'b0, dut.buf_cnt_q} + 3'(dut.inflight_q) <= 3'd2), 32'd1);

    // one cycle: drive, check against the model, update the model, advance to the next negedge
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        logic acc, pop;
        wr_en = w; wr_data = d; rd_ready = r;
        #1;
        check("count", 32'(count), 32'(exp_count));
        check("empty", 32'(empty), 32'(exp_count == 0));
        check("full", 32'(full), 32'(exp_count == 256));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        if (want_valid) check("gap", 32'(rd_valid), 32'd1);
        if (mem_rd_en) begin
            check("addr", 32'(mem_rd_addr), 32'(exp_raddr));
            exp_raddr = exp_raddr + 8'd1;
        end
        if (stall_prev && rd_valid) check("stable", 32'(rd_data), 32'(stall_data));
        stall_prev = rd_valid && !rd_ready;
        stall_data = rd_data;
        pop = rd_valid && rd_ready;
        if (pop) begin
            if (q.size() == 0) check("spurious", 32'd1, 32'd0);
            else check("data", 32'(rd_data), 32'(q.pop_front()));
        end
        acc = w && exp_count != 256;
        exp_count = exp_count + int'(acc) - int'(pop);
        exp_ovf = w && !acc;
        if (acc) q.push_back(d);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_count != 0; i++) step(1'b0, 8'h00, 1'b1);
        check("drained", 32'(q.size()), 32'd0);
        check("drain_count", 32'(count), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_valid", 32'(rd_valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("idle_valid", 32'(rd_valid), 32'd0);
            check("idle_rden", 32'(mem_rd_en), 32'd0);
        end

        step(1'b1, 8'hA5, 1'b1);
        check("lat_rden", 32'(mem_rd_en), 32'd1);
        check("lat_addr", 32'(mem_rd_addr), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        check("lat_valid", 32'(rd_valid), 32'd1);
        check("lat_data", 32'(rd_data), 32'hA5);
        step(1'b0, 8'h00, 1'b1);
        check("lat_empty", 32'(empty), 32'd1);

        for (int i = 0; i < 256; i++) step(1'b1, 8'(i), 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd256);
        step(1'b1, 8'hEE, 1'b0);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd256);
        step(1'b0, 8'h00, 1'b0);
        check("ovf_end", 32'(overflow), 32'd0);
        drain();

        for (int i = 0; i < 600; i++) begin
            want_valid = i >= 2;
            step(1'b1, 8'(i) ^ 8'h3C, 1'b1);
        end
        want_valid = 1'b0;
        drain();

        for (int i = 0; i < 400; i++) step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom));
        drain();

        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        wr_en = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_count", 32'(count), 32'd0);
        check("mid_empty", 32'(empty), 32'd1);
        check("mid_full", 32'(full), 32'd0);
        check("mid_ovf", 32'(overflow), 32'd0);
        check("mid_valid", 32'(rd_valid), 32'd0);
        check("mid_data", 32'(rd_data), 32'd0);
        check("mid_rden", 32'(mem_rd_en), 32'd0);
        check("mid_addr", 32'(mem_rd_addr), 32'd0);
        q.delete();
        exp_count = 0; exp_ovf = 1'b0; exp_raddr = 8'h00; stall_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h5A, 1'b1);
        check("post_rden", 32'(mem_rd_en), 32'd1);
        check("post_addr", 32'(mem_rd_addr), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        check("post_data", 32'(rd_data), 32'h5A);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller for the partitioned FIFO, sitting directly downstream of the write partition that drives the 256×8 storage memory through its address generator. Tracks occupancy from the writer's commit strobe, generates wrapping read addresses, and issues synchronous memory reads. Delivers entries through a 2-entry output buffer on a valid/ready interface with full throughput under backpressure. Exports `full` so the write-enable mux upstream can be gated.

## Interface
- `DATA_WIDTH`, 8: width of a stored entry.
- `MAX_DATA`, 256: memory depth; must be a power of two.
- `ADDR_WIDTH`, 8: log2(`MAX_DATA`).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  writer commit strobe; high in the same cycle the writer's memory write takes effect at the edge.
- `mem_rd_en`  out  1  memory read request.
- `mem_rd_addr`  out  ADDR_WIDTH  memory read address.
- `mem_rd_data`  in  DATA_WIDTH  memory read data; valid the cycle after `mem_rd_en`.
- `rd_data`  out  DATA_WIDTH  head entry.
- `rd_valid`  out  1  `rd_data` holds an entry.
- `rd_ready`  in  1  consumer accepts; pop = `rd_valid && rd_ready`.
- `count`  out  ADDR_WIDTH+1  true occupancy: written and not yet popped.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == MAX_DATA`.
- `overflow`  out  1  one-cycle pulse when `wr_en` arrives while `full`.

## Operation
- Reset values: `count` 0, `empty` 1, `full` 0, `overflow` 0, `rd_valid` 0, `rd_data` 0, `mem_rd_en` 0, `mem_rd_addr` 0. The in-flight flag, buffer and unfetched counter are cleared.
- Accepted write: `wr_en && !full`. `wr_en` while full is dropped and does not change `count`. It pulses `overflow` on the next cycle.
- `count` update rules:
  - +1 on accepted write.
  - −1 on pop.
  - Unchanged when both occur in the same cycle.
- Internal `unfetched` = `count` − buffered − in-flight. It gains an entry on an accepted write and loses one on a fetch. A write and a fetch in the same cycle leave it unchanged.
- Fetch condition (combinational):
  - `mem_rd_en` = `unfetched > 0 && (buffered + inflight − pop) < 2`.
  - `mem_rd_addr` = current read pointer.
  - The pointer increments after each fetch and wraps from `MAX_DATA−1` to 0.
- In-flight flag is set the cycle after `mem_rd_en`. `mem_rd_data` is written into the buffer tail at that edge.
- Output buffer:
  - 2-entry FIFO; the head drives `rd_data`/`rd_valid`.
  - Pop shifts the second entry to the head.
  - A simultaneous pop and fill keep order: the older entry is always presented first.
  - `rd_data` holds its last value while `rd_valid` = 0.
- `rd_data` must remain stable while `rd_valid && !rd_ready`.
- Overrun of the buffer is impossible by construction. An assertion in the bench checks it.
- Reset mid-operation discards all buffered and in-flight data. The read pointer returns to 0 regardless of the writer's pointer, so writer and reader are reset together.

## Timing
- `wr_en` in cycle t → `count` and `empty` reflect the write in cycle t+1. `mem_rd_en` can go high in t+1; `rd_valid` goes high in t+2. Write-to-valid latency is 2 cycles.
- Read-after-write to the same address is safe: the fetch is never earlier than the cycle after the write edge.
- Sustained throughput: 1 pop/cycle with `rd_ready` held high and writes keeping pace.
- After `rd_ready` deasserts, at most one more fetch lands, filling the buffer to 2. Fetching stops until a pop.
- `full` asserts in the cycle after the 256th unpopped accepted write. It deasserts in the cycle after the next pop.
- `overflow` is registered: high for exactly one cycle, at t+1 for an offending `wr_en` at t.

## Test plan
- Reset then idle 10 cycles → `empty`=1, `count`=0, `rd_valid`=0, `mem_rd_en`=0 throughout.
- Single write of 0xA5 at cycle t, `rd_ready`=1:
  - `mem_rd_en`=1 with addr 0 at t+1.
  - `rd_valid`=1 with `rd_data`=0xA5 at t+2.
  - `empty`=1 again at t+3.
- Write 256 entries (values 0..255) with `rd_ready`=0:
  - `full`=1 and `count`=256.
  - A 257th `wr_en` → `overflow` pulse, `count` stays 256.
  - Drain → data 0..255 in order.
- Continuous streaming of 600 entries, `rd_ready`=1 → pointer wraps twice, data in order, no gaps after the initial 2-cycle latency.
- Backpressure: stream with `rd_ready` toggled pseudo-randomly → order preserved and `rd_data` stable while stalled. Buffer occupancy never exceeds 2.
- Assert `rst` with 5 entries buffered/in flight:
  - All outputs return to reset values immediately.
  - After release, new writes are read from address 0.
